// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan path: scan FSM states and the
// board's segment bit positions ({E,D,A,F,C,G,B}, bit0 = B).
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_e;

    localparam int SEG_B = 0;
    localparam int SEG_G = 1;
    localparam int SEG_C = 2;
    localparam int SEG_F = 3;
    localparam int SEG_A = 4;
    localparam int SEG_D = 5;
    localparam int SEG_E = 6;

    // Maps a conventional {A,B,C,D,E,F,G} pattern onto the board bit order.
    function automatic logic [6:0] seg_pack(input logic [6:0] abcdefg);
        logic [6:0] s;
        s        = '0;
        s[SEG_A] = abcdefg[6];
        s[SEG_B] = abcdefg[5];
        s[SEG_C] = abcdefg[4];
        s[SEG_D] = abcdefg[3];
        s[SEG_E] = abcdefg[2];
        s[SEG_F] = abcdefg[1];
        s[SEG_G] = abcdefg[0];
        return s;
    endfunction

endpackage

// File: rtl/hexseg.sv
// Hex nibble to 7-segment decoder (active-high segments, board bit order).
// A low enable blanks all segments.
module hexseg
    import display_pkg::*;
(
    input  logic       en,
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] abcdefg;

    always_comb begin
        abcdefg = 7'b0000000;
        case (nibble)
            4'h0: abcdefg = 7'b1111110;
            4'h1: abcdefg = 7'b0110000;
            4'h2: abcdefg = 7'b1101101;
            4'h3: abcdefg = 7'b1111001;
            4'h4: abcdefg = 7'b0110011;
            4'h5: abcdefg = 7'b1011011;
            4'h6: abcdefg = 7'b1011111;
            4'h7: abcdefg = 7'b1110000;
            4'h8: abcdefg = 7'b1111111;
            4'h9: abcdefg = 7'b1111011;
            4'hA: abcdefg = 7'b1110111;
            4'hB: abcdefg = 7'b0011111;
            4'hC: abcdefg = 7'b1001110;
            4'hD: abcdefg = 7'b0111101;
            4'hE: abcdefg = 7'b1001111;
            4'hF: abcdefg = 7'b1000111;
            default: abcdefg = 7'b0000000;
        endcase
    end

    always_comb begin
        seg = '0;
        if (en) begin
            seg = seg_pack(abcdefg);
        end
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed scan driver for an NDIGITS 7-segment display: tear-free frame
// updates, blanking gap between digits, optional leading-zero suppression.
module display_scan
    import display_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 load,
    input  logic [4*NDIGITS-1:0] value,
    input  logic                 lz_en,
    output logic [6:0]           seg,
    output logic [NDIGITS-1:0]   dig_n,
    output logic                 frame_tick
);

    localparam int W     = 4 * NDIGITS;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIGITS - 1);

    scan_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       shown_q, shown_d;
    logic [W-1:0]       pending_q, pending_d;
    logic               pend_v_q, pend_v_d;
    logic [6:0]         seg_q, seg_d;
    logic [NDIGITS-1:0] dig_n_q, dig_n_d;
    logic               frame_tick_q, frame_tick_d;

    logic [NDIGITS-1:0] lz_blank;
    logic               zero_from;
    logic [3:0]         nibble;
    logic               suppress;
    logic               dec_en;

    // Slot sequencing and the double-buffered display word.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shown_d      = shown_q;
        pending_d    = pending_q;
        pend_v_d     = pend_v_q;
        frame_tick_d = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                    end
                end
                ON: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            // Frame boundary: the only point where shown may change.
                            idx_d        = '0;
                            frame_tick_d = 1'b1;
                            if (pend_v_q) begin
                                shown_d  = pending_q;
                                pend_v_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // A load coinciding with the frame update lands in pending for the next frame.
        if (load) begin
            pending_d = value;
            pend_v_d  = 1'b1;
        end
    end

    // Outputs are decoded from the next state so seg and dig_n switch together.
    always_comb begin
        zero_from = 1'b1;
        lz_blank  = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_from   = zero_from && (shown_d[4*i +: 4] == 4'h0);
            lz_blank[i] = (i != 0) && zero_from;
        end

        nibble   = 4'h0;
        suppress = 1'b0;
        dig_n_d  = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nibble   = shown_d[4*i +: 4];
                suppress = lz_en && lz_blank[i];
                if (state_d == ON) begin
                    dig_n_d[i] = 1'b0;
                end
            end
        end

        dec_en = (state_d == ON) && !suppress;
    end

    hexseg u_hexseg (
        .en     (dec_en),
        .nibble (nibble),
        .seg    (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shown_q      <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            seg_q        <= '0;
            dig_n_q      <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            seg_q        <= seg_d;
            dig_n_q      <= dig_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dig_n      = dig_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed stimulus pushes expected digit slots into a
// queue; a negedge monitor pops one entry per observed ON slot and compares.
module tb_display_scan;

    localparam int NDIGITS      = 4;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int ON_LEN       = SCAN_DIV - BLANK_CYCLES;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        lz_en;
    logic [6:0]  seg;
    logic [3:0]  dig_n;
    logic        frame_tick;

    int vectors     = 0;
    int miscompares = 0;

    // Entry: {dig_n[3:0], seg[6:0], gap_before[7:0]}; gap 0 means not checked.
    logic [18:0] exp_q[$];

    display_scan #(
        .NDIGITS      (NDIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .lz_en      (lz_en),
        .seg        (seg),
        .dig_n      (dig_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] mk(input logic [3:0] d, input logic [6:0] s, input logic [7:0] g);
        return {d, s, g};
    endfunction

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [7:0] g0);
        exp_q.push_back(mk(4'b1110, s0, g0));
        exp_q.push_back(mk(4'b1101, s1, 8'd2));
        exp_q.push_back(mk(4'b1011, s2, 8'd2));
        exp_q.push_back(mk(4'b0111, s3, 8'd2));
    endtask

    // Monitor: tracks ON runs of a single digit select and scores each one.
    bit          on_run = 1'b0;
    logic [3:0]  run_dig;
    logic [6:0]  run_seg;
    int          run_len = 0;
    int          off_len = 0;
    int          run_gap = 0;
    bit          run_tracked = 1'b0;
    bit          seg_stable = 1'b1;

    always @(negedge clk) begin : monitor
        int          zeros;
        logic [18:0] e;
        zeros = 0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (dig_n[i] == 1'b0) zeros++;
        end
        check("dig_sel", (zeros <= 1 && (dig_n != 4'hF || seg == 7'h00)) ? 1 : 0, 1);

        if (on_run && (dig_n == 4'hF || dig_n != run_dig)) begin
            on_run = 1'b0;
            if (run_tracked && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("slot_dig", int'(run_dig), int'(e[18:15]));
                check("slot_seg", int'(run_seg), int'(e[14:8]));
                check("seg_stable", int'(seg_stable), 1);
                check("on_len", run_len, ON_LEN);
                if (e[7:0] != 8'd0) check("gap_len", run_gap, int'(e[7:0]));
            end
        end
        if (dig_n != 4'hF && !on_run) begin
            on_run      = 1'b1;
            run_dig     = dig_n;
            run_seg     = seg;
            run_len     = 0;
            run_gap     = off_len;
            off_len     = 0;
            seg_stable  = 1'b1;
            run_tracked = (exp_q.size() > 0);
        end
        if (on_run) begin
            run_len++;
            if (seg != run_seg) seg_stable = 1'b0;
        end else begin
            off_len++;
        end
    end

    task automatic wait_tick(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = frame_tick;
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    task automatic wait_dig(input logic [3:0] pat);
        int n;
        n = 0;
        while (dig_n != pat && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (dig_n != pat) check("dig_timeout", int'(dig_n), int'(pat));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b1;
        load   = 1'b0;
        value  = 16'h0000;
        lz_en  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dig_n", int'(dig_n), 4'hF);
        check("rst_seg", int'(seg), 0);
        check("rst_tick", int'(frame_tick), 0);

        // Start-up: frame 0 shows the reset value 0000
        push_frame(7'h7D, 7'h7D, 7'h7D, 7'h7D, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("startup_blank", int'(dig_n), 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("startup_dig0", int'(dig_n), 4'b1110);

        // First frame after load of 1234
        do_load(16'h1234);
        wait_tick(n);
        push_frame(7'h0F, 7'h37, 7'h73, 7'h05, 8'd2);
        wait_tick(n);
        check("tick_period", n, NDIGITS * SCAN_DIV);

        // Tear-free update: load ABCD during digit 1 of a 1234 frame
        push_frame(7'h0F, 7'h37, 7'h73, 7'h05, 8'd2);
        wait_dig(4'b1101);
        do_load(16'hABCD);
        wait_tick(n);
        push_frame(7'h67, 7'h78, 7'h6E, 7'h5F, 8'd2);
        wait_drain();

        // Leading-zero suppression
        lz_en = 1'b1;
        wait_tick(n);
        do_load(16'h0005);
        wait_tick(n);
        push_frame(7'h3E, 7'h00, 7'h00, 7'h00, 8'd2);
        do_load(16'h0000);
        wait_tick(n);
        push_frame(7'h7D, 7'h00, 7'h00, 7'h00, 8'd2);
        wait_drain();

        // Back-to-back loads: last one wins
        lz_en = 1'b0;
        wait_tick(n);
        load  = 1'b1;
        value = 16'h1111;
        @(negedge clk);
        value = 16'h2222;
        @(negedge clk);
        load  = 1'b0;
        wait_tick(n);
        push_frame(7'h73, 7'h73, 7'h73, 7'h73, 8'd2);
        wait_drain();

        // Enable drop mid-ON, then restart from digit 0
        wait_dig(4'b1011);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("en_drop_dig_n", int'(dig_n), 4'hF);
        check("en_drop_seg", int'(seg), 0);
        repeat (4) @(negedge clk);
        push_frame(7'h73, 7'h73, 7'h73, 7'h73, 8'd0);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reen_blank", int'(dig_n), 4'hF);
        @(negedge clk);
        check("reen_dig0", int'(dig_n), 4'b1110);
        wait_drain();

        // Asynchronous reset mid-ON with a value pending
        do_load(16'h9999);
        wait_dig(4'b1101);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dig_n", int'(dig_n), 4'hF);
        check("async_rst_seg", int'(seg), 0);
        check("async_rst_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(7'h7D, 7'h7D, 7'h7D, 7'h7D, 8'd0);
        wait_tick(n);
        check("post_rst_tick", n, NDIGITS * SCAN_DIV + 1);
        push_frame(7'h7D, 7'h7D, 7'h7D, 7'h7D, 8'd2);
        wait_drain();

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
